// File: rtl/svcs_hs_frame_packer.sv
// Buffers one transaction's payload, then emits a 7-word header plus the payload as a framed stream.
// Optional trailer word (XOR of payload) enabled by defining SVCS_FRAME_CHECKSUM_EN.
module svcs_hs_frame_packer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       cfg_trnx_type,
    input  logic [63:0]       cfg_trnx_id,
    input  logic [63:0]       cfg_data_type,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_sof,
    output logic              out_eof,
    output logic              busy,
    output logic              ovf_err,
    output logic [15:0]       frame_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(DEPTH + 9);

    typedef enum logic [1:0] {FILL, HDR, PAY} state_t;

    state_t            state, state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [CW-1:0]     cnt, n;
    logic [PW-1:0]     pos, nxt_pos, pay_idx, last_pos;
    logic [31:0]       ty_lo;
    logic [63:0]       id, dt;
    logic [DATA_W-1:0] nxt_word;
    logic              accept, close, hs, nxt_eof;

    assign accept = in_valid && in_ready;
    assign close  = accept && (in_last || cnt == CW'(DEPTH - 1));
    assign hs     = out_valid && out_ready;
    assign busy   = (state != FILL);

`ifdef SVCS_FRAME_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            csum <= '0;
        else if (accept)
            csum <= (cnt == '0) ? in_data : (csum ^ in_data);
    end

    assign last_pos = PW'(n) + PW'(7);
`else
    assign last_pos = PW'(n) + PW'(6);
`endif

    always_ff @(posedge clk) begin
        if (accept)
            mem[cnt[AW-1:0]] <= in_data;
    end

    // Word that follows the one currently presented; loaded on its handshake.
    always_comb begin
        state_d  = state;
        nxt_pos  = pos + PW'(1);
        pay_idx  = nxt_pos - PW'(7);
        nxt_eof  = (nxt_pos == last_pos);
        nxt_word = '0;
        case (nxt_pos)
            PW'(1): nxt_word = ty_lo;
            PW'(2): nxt_word = id[63:32];
            PW'(3): nxt_word = id[31:0];
            PW'(4): nxt_word = dt[63:32];
            PW'(5): nxt_word = dt[31:0];
            PW'(6): nxt_word = DATA_W'(n);
            default: begin
                if (pay_idx < PW'(n))
                    nxt_word = mem[pay_idx[AW-1:0]];
`ifdef SVCS_FRAME_CHECKSUM_EN
                else
                    nxt_word = csum;
`endif
            end
        endcase
        case (state)
            FILL:    if (close) state_d = HDR;
            HDR:     if (hs && pos == PW'(6)) state_d = PAY;
            PAY:     if (hs && out_eof) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            in_ready  <= 1'b0;
            cnt       <= '0;
            n         <= '0;
            pos       <= '0;
            ty_lo     <= '0;
            id        <= '0;
            dt        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            ovf_err   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state    <= state_d;
            in_ready <= (state_d == FILL);
            if (accept)
                cnt <= cnt + CW'(1);
            if (close) begin
                ty_lo     <= cfg_trnx_type[31:0];
                id        <= cfg_trnx_id;
                dt        <= cfg_data_type;
                n         <= cnt + CW'(1);
                // Closing without in_last can only be the DEPTH-th word.
                if (!in_last)
                    ovf_err <= 1'b1;
                pos       <= '0;
                out_valid <= 1'b1;
                out_data  <= cfg_trnx_type[63:32];
                out_sof   <= 1'b1;
                out_eof   <= 1'b0;
            end else if (hs) begin
                if (out_eof) begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    out_sof   <= 1'b0;
                    out_eof   <= 1'b0;
                    cnt       <= '0;
                    frame_cnt <= frame_cnt + 16'd1;
                end else begin
                    pos      <= nxt_pos;
                    out_data <= nxt_word;
                    out_sof  <= 1'b0;
                    out_eof  <= nxt_eof;
                end
            end
        end
    end
endmodule

// File: tb/tb_svcs_hs_frame_packer.sv
// Self-checking bench for svcs_hs_frame_packer (DEPTH=4) against a queue-based frame model.
module tb_svcs_hs_frame_packer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] cfg_trnx_type, cfg_trnx_id, cfg_data_type;
    logic        in_valid, in_ready, in_last;
    logic [31:0] in_data;
    logic        out_valid, out_ready, out_sof, out_eof, busy, ovf_err;
    logic [31:0] out_data;
    logic [15:0] frame_cnt;

    svcs_hs_frame_packer #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cfg_trnx_type(cfg_trnx_type), .cfg_trnx_id(cfg_trnx_id), .cfg_data_type(cfg_data_type),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .ovf_err(ovf_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          mode = 0;
    int          drain_limit = -1;
    logic [31:0] chunk[$];
    logic [31:0] exp_q[$];
    logic        exp_ovf = 1'b0;
    logic [15:0] exp_fc = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected frame: header halves, n, payload, optional XOR trailer.
    task automatic make_frame();
        logic [31:0] x;
        x = '0;
        exp_q.delete();
        exp_q.push_back(cfg_trnx_type[63:32]);
        exp_q.push_back(cfg_trnx_type[31:0]);
        exp_q.push_back(cfg_trnx_id[63:32]);
        exp_q.push_back(cfg_trnx_id[31:0]);
        exp_q.push_back(cfg_data_type[63:32]);
        exp_q.push_back(cfg_data_type[31:0]);
        exp_q.push_back(32'(chunk.size()));
        foreach (chunk[i]) begin
            exp_q.push_back(chunk[i]);
            x = x ^ chunk[i];
        end
`ifdef SVCS_FRAME_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic drain();
        int idx = 0;
        int cyc = 0;
        logic rdy;
        while (idx < exp_q.size()) begin
            if (drain_limit >= 0 && idx == drain_limit) return;
            if (cyc > 500) begin
                chk("drain_timeout", 64'(idx), 64'(exp_q.size()));
                return;
            end
            chk("out_valid", out_valid, 1'b1);
            chk("out_data", out_data, exp_q[idx]);
            chk("out_sof", out_sof, idx == 0);
            chk("out_eof", out_eof, idx == exp_q.size() - 1);
            chk("busy", busy, 1'b1);
            chk("in_ready_busy", in_ready, 1'b0);
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            else                rdy = 1'($urandom_range(0, 1));
            out_ready = rdy;
            @(negedge clk);
            if (rdy) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        exp_fc++;
        chk("frame_cnt", frame_cnt, exp_fc);
        chk("valid_after_eof", out_valid, 1'b0);
        chk("in_ready_after_eof", in_ready, 1'b1);
        chk("busy_after_eof", busy, 1'b0);
    endtask

    task automatic send_beat(input logic [31:0] data, input logic last);
        int b = 0;
        while (in_ready !== 1'b1) begin
            if (b > 50) begin
                chk("in_ready_wait", in_ready, 1'b1);
                return;
            end
            @(negedge clk);
            b++;
        end
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chunk.push_back(data);
        if (last || chunk.size() == DEPTH) begin
            if (!last) exp_ovf = 1'b1;
            make_frame();
            chunk.delete();
            chk("latency_sof", out_sof, 1'b1);
            chk("ovf_err", ovf_err, exp_ovf);
            drain();
        end else begin
            chk("in_ready_fill", in_ready, 1'b1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_sof_eof", {out_sof, out_eof}, 2'b00);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", ovf_err, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 16'h0);
        chunk.delete();
        exp_ovf = 1'b0;
        exp_fc  = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_post_rst", in_ready, 1'b1);
        repeat (2) begin
            chk("idle_out_valid", out_valid, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic std_cfg();
        cfg_trnx_type = 64'h3FF0000000000000;
        cfg_trnx_id   = 64'h4000000000000000;
        cfg_data_type = 64'h4008000000000000;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
        std_cfg();
        @(negedge clk);
        do_reset();

        // single frame, then same frame under 1,0,0,1 backpressure
        mode = 0;
        send_beat(32'hA, 1'b0); send_beat(32'hB, 1'b0); send_beat(32'hC, 1'b1);
        mode = 1;
        send_beat(32'hA, 1'b0); send_beat(32'hB, 1'b0); send_beat(32'hC, 1'b1);

        // overflow: 1..6 with last on 6 -> frames of 4 and 2, ovf sticky
        mode = 0;
        for (int i = 1; i <= 6; i++) send_beat(32'(i), i == 6);
        chk("ovf_sticky", ovf_err, 1'b1);
        do_reset();

        // exact fill: last on DEPTH-th word
        for (int i = 1; i <= 4; i++) send_beat(32'(i + 16), i == 4);
        chk("exact_fill_ovf", ovf_err, 1'b0);

        send_beat(32'hF0, 1'b0); send_beat(32'h0F, 1'b0); send_beat(32'hFF, 1'b1);

        // reset after 8 output words of a 3-word frame
        drain_limit = 8;
        send_beat(32'h11, 1'b0); send_beat(32'h22, 1'b0); send_beat(32'h33, 1'b1);
        drain_limit = -1;
        out_ready = 1'b0;
        do_reset();
        send_beat(32'h55, 1'b1);

        // randomized transactions and backpressure
        mode = 2;
        for (int t = 0; t < 20; t++) begin
            int len;
            len = $urandom_range(1, 10);
            cfg_trnx_type = {$urandom, $urandom};
            cfg_trnx_id   = {$urandom, $urandom};
            cfg_data_type = {$urandom, $urandom};
            for (int i = 0; i < len; i++) send_beat($urandom, i == len - 1);
        end
        chk("final_ovf", ovf_err, exp_ovf);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/svcs_hs_frame_packer.md
Name: svcs_hs_frame_packer

Overview:
- RTL-side producer stage directly upstream of the SVCS DPI handshake send path.
- Collects one transaction's payload words into an internal buffer, then emits a framed word stream that the testbench send loop drains and forwards as one header plus payload:
  - header fields trnx_type, trnx_id, data_type, n_payloads;
  - payload words.
- Real-valued header fields are carried as raw 64-bit IEEE-754 bit patterns.

Parameters:
- DATA_W, 32: payload and output word width. Fixed at 32 because the header is split into 32-bit words.
- DEPTH, 64: maximum payload words per transaction (buffer size). Power of 2, ≥ 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_trnx_type  in  64  trnx_type bit pattern; sampled on the accepted in_last beat.
- cfg_trnx_id  in  64  trnx_id bit pattern; sampled with cfg_trnx_type.
- cfg_data_type  in  64  data_type bit pattern; sampled with cfg_trnx_type.
- in_valid  in  1  payload word valid.
- in_ready  out  1  payload word accepted when in_valid && in_ready.
- in_data  in  DATA_W  payload word.
- in_last  in  1  marks the final payload word of a transaction.
- out_valid  out  1  framed word valid.
- out_ready  in  1  downstream accepts the word when out_valid && out_ready.
- out_data  out  32  framed word.
- out_sof  out  1  high with header word 0.
- out_eof  out  1  high with the final word of the frame.
- busy  out  1  high in HDR or PAY.
- ovf_err  out  1  sticky flag: a frame was truncated at DEPTH.
- frame_cnt  out  16  count of completed frames; wraps 0xFFFF -> 0.

Behaviour:
- Reset values (async, all outputs):
  - in_ready=0 while rst is high, 1 in the first cycle after release.
  - out_valid=0, out_data=0, out_sof=0, out_eof=0, busy=0, ovf_err=0, frame_cnt=0.
  - State is FILL and the word count is 0.
- FSM state FILL:
  - in_ready=1; each accepted beat writes buf[cnt] and increments cnt.
  - An accepted beat with in_last, or the beat that makes cnt==DEPTH, closes the frame:
    - latch cfg_* and n = cnt+1;
    - next state is HDR.
- Overflow:
  - If the closing beat is the DEPTH-th word and in_last=0, set ovf_err.
  - Subsequent input words belong to the next frame.
- FSM state HDR:
  - in_ready=0, busy=1.
  - Emits 7 words in this order:
    1. type[63:32]
    2. type[31:0]
    3. id[63:32]
    4. id[31:0]
    5. dtype[63:32]
    6. dtype[31:0]
    7. n zero-extended to 32 bits
  - out_sof=1 on word 1 only.
- FSM state PAY:
  - Emits buf[0..n-1]; out_eof=1 with buf[n-1].
  - n ≥ 1 always, because in_last always rides on a data beat.
- Frame completion:
  - On the handshake of the out_eof word: frame_cnt++, cnt=0, state returns to FILL.
  - in_ready=1 in the following cycle.
- Latency:
  - Frame closes at edge N: out_valid=1 with header word 0 from cycle N+1 (registered outputs).
- Throughput:
  - With out_ready held high, one word per cycle and no bubbles across the HDR->PAY boundary.
  - Total frame length is 7+n cycles.
- Output stability:
  - While out_valid && !out_ready, out_data, out_sof and out_eof hold stable.
  - out_valid never drops without a handshake.
- Reset mid-operation:
  - Any partial or in-flight frame is discarded with no further output words.
  - ovf_err and frame_cnt are cleared.
- Simultaneous events:
  - Input is not accepted while busy, so no overlap exists.
  - in_last together with cnt==DEPTH-1 closes normally; ovf_err is not set.
- Arithmetic:
  - cnt is clog2(DEPTH)+1 bits; n is reported unsigned.

Optional Feature:
- Macro: SVCS_FRAME_CHECKSUM_EN.
- Defined:
  - After buf[n-1], one trailer word equal to the XOR of all n payload words is emitted.
  - out_eof moves to the trailer; the frame is 8+n words.
  - Header word 7 still carries n, excluding the trailer.
- Undefined:
  - No trailer; out_eof is on buf[n-1].

Test Plan:
- Single frame:
  - Stimulus: type=0x3FF0000000000000, id=0x4000000000000000, dtype=0x4008000000000000; payload 0xA,0xB,0xC with last on 0xC; out_ready=1.
  - Required: 10 consecutive words 3FF00000,0,40000000,0,40080000,0,3,A,B,C.
  - sof on word 1, eof on 0xC, frame_cnt=1.
- Backpressure:
  - Stimulus: same frame; out_ready toggled 1,0,0,1 repeatedly.
  - Required: identical word sequence, outputs stable while stalled, in_ready=0 until after eof.
- Overflow (DEPTH=4):
  - Stimulus: 6 words 1..6, last only on 6.
  - Required: frame 1 has n=4 with payload 1..4 and ovf_err=1; frame 2 has n=2 with payload 5,6; ovf_err stays 1.
- Exact fill (DEPTH=4):
  - Stimulus: 4 words with last on word 4.
  - Required: n=4, ovf_err=0.
- Reset mid-PAY:
  - Stimulus: assert rst after 8 output words of the 3-word frame.
  - Required: out_valid=0 immediately; no further words; frame_cnt=0.
  - Next frame of 1 word emits a full 8-word frame.
- Checksum (macro defined):
  - Stimulus: payload 0xF0,0x0F,0xFF.
  - Required: trailer 0x00000000 with eof; header word 7 = 3.
